// File: rtl/mem_stream_reader.sv
// mem_stream_reader
//   Read-side burst engine for the feature-map / gradient dual-port memories.
//   Issues consecutive port-B reads and returns the words as a valid/ready
//   stream, hiding the 1-cycle read latency and downstream stalls behind a
//   2-entry first-word-fall-through buffer.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base_addr, len burst request (sampled in IDLE only)
//   busy, done            burst in progress / one-cycle completion pulse
//   enb, addrb, doutb     memory port B (read data valid 1 cycle after enb)
//   m_data, m_valid,
//   m_ready, m_last       output stream; m_last marks the final beat
module mem_stream_reader #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16,
  parameter int LW         = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] base_addr,
  input  logic [LW-1:0]            len,
  output logic                     busy,
  output logic                     done,
  output logic                     enb,
  output logic [$clog2(DEPTH)-1:0] addrb,
  input  logic [BIT_LENGTH-1:0]    doutb,
  output logic [BIT_LENGTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         base_q, base_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         issued_q, issued_d;
  logic [LW-1:0]         beats_q, beats_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [BIT_LENGTH-1:0] buf0_q, buf0_d;
  logic [BIT_LENGTH-1:0] buf1_q, buf1_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic                  issue_ok;
  logic [2:0]            pending;
  logic [1:0]            head_idx;
  logic [BIT_LENGTH-1:0] ent [4];

  // The in-flight word is presented straight from doutb when the buffer is
  // empty, so the first beat is visible one cycle after its enb.
  always_comb begin
    m_valid = (occ_q != 2'd0) || inflight_q;
    if (occ_q != 2'd0) begin
      m_data = buf0_q;
    end else if (inflight_q) begin
      m_data = doutb;
    end else begin
      m_data = '0;
    end
    m_last = m_valid && (beats_q == len_q - LW'(1));
    pop    = m_valid && m_ready;
    busy   = (state_q != IDLE);
    done   = done_q;
  end

  // Words owed to the stream (buffered + in flight) after this cycle's pop.
  always_comb begin
    pending  = {1'b0, occ_q} + {2'b00, inflight_q};
    issue_ok = pending < (3'd2 + {2'b00, pop});
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    beats_d  = beats_q;
    done_d   = 1'b0;
    enb      = 1'b0;
    addrb    = '0;

    if (pop) begin
      beats_d = beats_q + LW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            base_d   = base_addr;
            len_d    = len;
            issued_d = '0;
            beats_d  = '0;
            state_d  = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue_ok) begin
          enb      = 1'b1;
          addrb    = base_q + issued_q[AW-1:0];
          issued_d = issued_q + LW'(1);
          if (issued_q + LW'(1) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ordered view of pending words: buffered entries first, then the word
  // arriving on doutb; the new head is selected past any popped entry.
  always_comb begin
    ent[0] = buf0_q;
    ent[1] = buf1_q;
    ent[2] = '0;
    ent[3] = '0;
    if (inflight_q) begin
      ent[occ_q] = doutb;
    end
    head_idx   = {1'b0, pop};
    buf0_d     = ent[head_idx];
    buf1_d     = ent[head_idx + 2'd1];
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    inflight_d = enb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

  localparam int BL    = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy, done, enb;
  logic [AW-1:0] addrb;
  logic [BL-1:0] doutb;
  logic [BL-1:0] m_data;
  logic          m_valid, m_ready, m_last;

  logic [BL-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  mem_stream_reader #(
    .BIT_LENGTH(BL),
    .DEPTH(DEPTH),
    .LW(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .busy(busy),
    .done(done),
    .enb(enb),
    .addrb(addrb),
    .doutb(doutb),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Port-B memory: synchronous read, data valid the cycle after enb.
  always @(posedge clk) begin
    if (enb) doutb <= mem[addrb];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < DEPTH; i++) begin
      if (rnd) mem[i] = {$urandom(), $urandom()};
      else     mem[i] = BL'(i + 100);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [AW+BL+4:0] obs;
    obs = {busy, done, enb, m_valid, m_last, addrb, m_data};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs {busy,done,enb,m_valid,m_last,addrb,m_data} = %h, required 0", name, obs);
    end
  endtask

  // Runs one burst and checks it against the expected word sequence.
  // mode 0: m_ready=1, 1: fixed 1,0,0,1,0,1 pattern, 2: random m_ready.
  // inject_at >= 0 pulses a conflicting start at that busy cycle.
  task automatic run_burst(input int b, input int n, input int mode, input int inject_at, input string name);
    logic [BL-1:0] expq[$];
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    int issues = 0, accepted = 0, ccount = 0;
    int first_enb = -1, first_valid = -1, last_beat = -1;
    bit got_done = 0;
    bit popped, exp_enb;
    int outstanding;
    logic [AW-1:0] exp_addr;

    for (int i = 0; i < n; i++) expq.push_back(mem[(b + i) % DEPTH]);

    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); len = LW'(n); m_ready = 1'b1;

    while (!got_done && ccount < 300) begin
      @(posedge clk); #1;
      start = (ccount == inject_at);
      if (start) begin
        base_addr = AW'(b + 7);
        len       = LW'(3);
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[ccount % 6] != 0;
        default: m_ready = $urandom_range(0, 1) != 0;
      endcase
      @(negedge clk);

      popped      = m_valid && m_ready;
      outstanding = issues - accepted;
      exp_enb     = (issues < n) && ((outstanding - int'(popped)) < 2);

      n_checks++;
      if (enb !== exp_enb) begin
        n_fail++;
        $display("FAIL %s enb@%0d: got %b, required %b (issued %0d, accepted %0d)",
                 name, ccount, enb, exp_enb, issues, accepted);
      end

      if (enb) begin
        exp_addr = AW'((b + issues) % DEPTH);
        n_checks++;
        if (addrb !== exp_addr) begin
          n_fail++;
          $display("FAIL %s addrb@%0d: got %0d, required %0d", name, ccount, addrb, exp_addr);
        end
        if (first_enb < 0) first_enb = ccount;
        issues++;
      end

      if (m_valid && first_valid < 0) first_valid = ccount;

      if (popped) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_beat@%0d: got %h, required no beat", name, ccount, m_data);
        end else begin
          if (m_data !== expq[0] || m_last !== (accepted == n - 1)) begin
            n_fail++;
            $display("FAIL %s beat%0d: got data %h last %b, required data %h last %b",
                     name, accepted, m_data, m_last, expq[0], (accepted == n - 1));
          end
          void'(expq.pop_front());
        end
        if (accepted == n - 1) last_beat = ccount;
        accepted++;
      end

      if (done) begin
        got_done = 1;
        n_checks++;
        if (ccount !== last_beat + 1 || busy !== 1'b0 || accepted !== n) begin
          n_fail++;
          $display("FAIL %s done: at cycle %0d busy %b beats %0d, required cycle %0d busy 0 beats %0d",
                   name, ccount, busy, accepted, last_beat + 1, n);
        end
      end else begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy@%0d: got %b, required 1", name, ccount, busy);
        end
      end
      ccount++;
    end
    start = 1'b0;

    if (!got_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no done after %0d cycles, required done", name, ccount);
    end

    if (mode == 0) begin
      n_checks++;
      if (first_valid !== first_enb + 1 || last_beat - first_enb !== n) begin
        n_fail++;
        $display("FAIL %s throughput: got first_valid-first_enb %0d, last-first_enb %0d, required 1 and %0d",
                 name, first_valid - first_enb, last_beat - first_enb, n);
      end
    end

    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_done: got done %b busy %b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");
  endtask

  task automatic test_basic;
    fill_mem(0);
    run_burst(3, 4, 0, -1, "basic");
  endtask

  task automatic test_wrap;
    fill_mem(0);
    run_burst(14, 4, 0, -1, "wrap");
  endtask

  task automatic test_backpressure;
    fill_mem(1);
    run_burst(9, 6, 1, -1, "backpressure");
  endtask

  task automatic test_zero_len;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(5); len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || enb !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: got done %b busy %b enb %b, required 1 0 0", done, busy, enb);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || enb !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_len_after%0d: got done %b busy %b enb %b, required 0 0 0", i, done, busy, enb);
      end
    end
  endtask

  task automatic test_busy_start;
    fill_mem(1);
    run_burst(2, 5, 0, 2, "busy_start");
  endtask

  task automatic test_full;
    fill_mem(1);
    run_burst(0, 16, 0, -1, "full");
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      fill_mem(1);
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 2, -1, "random");
    end
  endtask

  task automatic test_reset_mid_burst;
    int beats = 0;
    int guard = 0;
    fill_mem(1);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(5); len = LW'(8); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (beats < 2 && guard < 50) begin
      @(negedge clk);
      if (m_valid && m_ready) beats++;
      guard++;
      if (beats < 2) begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (beats !== 2) begin
      n_fail++;
      $display("FAIL reset_mid_prep: got %0d beats, required 2", beats);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_async");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all_zero("reset_mid_hold");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all_zero("reset_mid_release");
      @(posedge clk); #1;
    end
    run_burst(0, 2, 0, -1, "after_reset_burst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_busy_start();
    test_full();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
